pmem_arbiter: RTL

// - Shares the single cacheline-wide physical memory port between the I-cache miss port and the D-cache miss/writeback port.
// - Sits between both caches and the cacheline adapter in the mp3 top level.
// - Serialises requests so that exactly one transaction is outstanding on pmem at a time.
// - Routes pmem_resp and pmem_rdata back to the requester that owns the transaction.

---
 rtl/pmem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter for the shared cacheline physical memory port.
// Define ARB_RR_EN for round-robin tie-break; default is fixed D-over-I priority.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_e;

    state_e state_q, state_d;
    logic   d_req;

    assign d_req   = d_read | d_write;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifdef ARB_RR_EN
    // 1 = D owned the most recent grant
    logic last_d_q, last_d_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
`ifdef ARB_RR_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_RR_EN
                if (d_req && i_read) begin
                    state_d = last_d_q ? GNT_I : GNT_D;
                end else if (d_req) begin
                    state_d = GNT_D;
                end else if (i_read) begin
                    state_d = GNT_I;
                end
                if (state_d != IDLE) begin
                    last_d_d = (state_d == GNT_D);
                end
`else
                if (d_req) begin
                    state_d = GNT_D;
                end else if (i_read) begin
                    state_d = GNT_I;
                end
`endif
            end
            GNT_D: begin
                pmem_read  = d_read;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp;
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            GNT_I: begin
                pmem_read = i_read;
                pmem_addr = i_addr;
                i_resp    = pmem_resp;
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
